// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/response bundle between the two masters and ram_arbiter
//   req/wr_rd/addr/wdata : per-master request fields, master i uses slice i
//   done/err             : per-master completion and read-timeout pulses
//   rdata                : shared read data, valid with done[i] && !err[i]
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [1:0]              req;
  logic [1:0]              wr_rd;
  logic [2*ADDR_WIDTH-1:0] addr;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [1:0]              done;
  logic [1:0]              err;
  logic [DATA_WIDTH-1:0]   rdata;
  modport master (output req, wr_rd, addr, wdata, input done, err, rdata);
  modport slave (input req, wr_rd, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master arbiter/sequencer for a single-port ram
//   clk, rstn    : clock (rising edge), asynchronous active-low reset
//   m            : master-side request bundle (ram_arbiter_if.slave)
//   ram_en, ram_wr_rd, ram_addr, ram_data_in : registered RAM controls
//   ram_data_out, ram_out_en                 : RAM read data and its qualifier
//   RAM_ARB_TIMEOUT_EN : when defined, reads abort with err after RD_TIMEOUT RWAIT cycles
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  ram_arbiter_if.slave          m,
  output logic                  ram_en,
  output logic                  ram_wr_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_out_en
);
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [1:0] done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, ram_data_in_q, ram_data_in_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic ram_en_q, ram_en_d, ram_wr_rd_q, ram_wr_rd_d;
  logic win, timeout;
  if (RD_TIMEOUT < 2) begin : g_bad_rd_timeout
    $error("ram_arbiter: RD_TIMEOUT must be >= 2");
  end
`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // Counts completed RWAIT cycles; zero in every other state so it is clear on entry.
  assign cnt_d = (state_q == RWAIT) ? cnt_q + 1'b1 : '0;
  assign timeout = cnt_q == CW'(RD_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  // Contention goes to the master that was not served last.
  assign win = (m.req[0] && m.req[1]) ? ~last_q : m.req[1];
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    done_d = '0;
    err_d = '0;
    rdata_d = rdata_q;
    ram_en_d = ram_en_q;
    ram_wr_rd_d = ram_wr_rd_q;
    ram_addr_d = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    case (state_q)
      IDLE: if (|m.req) begin
        state_d = ISSUE;
        owner_d = win;
        ram_en_d = 1'b1;
        ram_wr_rd_d = m.wr_rd[win];
        ram_addr_d = win ? m.addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m.addr[ADDR_WIDTH-1:0];
        ram_data_in_d = win ? m.wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m.wdata[DATA_WIDTH-1:0];
      end
      ISSUE: if (ram_wr_rd_q) begin
        state_d = DONE;
        ram_en_d = 1'b0;
        done_d[owner_q] = 1'b1;
        last_d = owner_q;
      end else state_d = RWAIT;
      RWAIT: if (ram_out_en || timeout) begin
        state_d = DONE;
        ram_en_d = 1'b0;
        done_d[owner_q] = 1'b1;
        err_d[owner_q] = !ram_out_en;
        last_d = owner_q;
        rdata_d = ram_out_en ? ram_data_out : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      done_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
      ram_en_q <= 1'b0;
      ram_wr_rd_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_in_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      done_q <= done_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      ram_en_q <= ram_en_d;
      ram_wr_rd_q <= ram_wr_rd_d;
      ram_addr_q <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
    end
  assign m.done = done_q;
  assign m.err = err_q;
  assign m.rdata = rdata_q;
  assign ram_en = ram_en_q;
  assign ram_wr_rd = ram_wr_rd_q;
  assign ram_addr = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural ram
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic ram_en, ram_wr_rd, ram_out_en, stall;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic [7:0] mem [16];
  int errors = 0, checks = 0;
  ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .m(bus),
    .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_out_en(ram_out_en)
  );
  always #5 clk = ~clk;
  // Single-port ram: write on the enabled edge, read data and out_en one edge later.
  always @(posedge clk) begin
    if (ram_en && ram_wr_rd) mem[ram_addr] <= ram_data_in;
    if (ram_en && !ram_wr_rd) ram_data_out <= mem[ram_addr];
    ram_out_en <= ram_en && !ram_wr_rd && !stall;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int i, input logic wr, input logic [3:0] a, input logic [7:0] d,
                     input int exp_lat, input logic [7:0] exp_rdata, input logic exp_err,
                     input string tag);
    int n = 0;
    bus.req[i] = 1'b1;
    bus.wr_rd[i] = wr;
    bus.addr[i*4 +: 4] = a;
    bus.wdata[i*8 +: 8] = d;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done[i] !== 1'b1 && n < 20);
    bus.req[i] = 1'b0;
    chk({tag, "_done"}, bus.done, 2'b01 << i);
    chk({tag, "_err"}, bus.err, exp_err ? (2'b01 << i) : 2'b00);
    chk({tag, "_rdata"}, bus.rdata, exp_rdata);
    chk({tag, "_lat"}, n, exp_lat);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, n;
    stall = 1'b0;
    rstn = 1'b0;
    bus.req = 2'b11;
    bus.wr_rd = 2'b11;
    bus.addr = {4'h2, 4'h1};
    bus.wdata = {8'h22, 8'h11};
    repeat (2) begin
      @(negedge clk);
      chk("reset_outs", {bus.done, bus.err, bus.rdata, ram_en, ram_wr_rd, ram_addr, ram_data_in}, 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("c_issue0", {ram_en, ram_wr_rd, ram_addr, ram_data_in}, {1'b1, 1'b1, 4'h1, 8'h11});
    @(negedge clk);
    chk("c_done0", bus.done, 2'b01);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("c_idle", {bus.done, ram_en}, 3'b000);
    @(negedge clk);
    chk("c_issue1", {ram_en, ram_wr_rd, ram_addr, ram_data_in}, {1'b1, 1'b1, 4'h2, 8'h22});
    @(negedge clk);
    chk("c_done1", bus.done, 2'b10);
    bus.req[1] = 1'b0;
    @(negedge clk);
    run(0, 1'b1, 4'h3, 8'hA5, 2, 8'h00, 1'b0, "w0");
    run(0, 1'b0, 4'h3, 8'h00, 3, 8'hA5, 1'b0, "r0");
    run(0, 1'b0, 4'h1, 8'h00, 3, 8'h11, 1'b0, "rb0");
    run(1, 1'b0, 4'h2, 8'h00, 3, 8'h22, 1'b0, "rb1");
    bus.wr_rd = 2'b11;
    bus.addr = {4'h9, 4'h8};
    bus.wdata = {8'h90, 8'h80};
    bus.req = 2'b11;
    k = 0;
    n = 0;
    while (k < 8 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done != 2'b00) begin
        chk($sformatf("fair%0d", k), bus.done, (k % 2) ? 2'b10 : 2'b01);
        k++;
      end
    end
    bus.req = 2'b00;
    chk("fair_count", k, 8);
    chk("fair_cycles", n, 23);
    @(negedge clk);
    stall = 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
    run(0, 1'b0, 4'h3, 8'h00, 6, 8'h22, 1'b1, "tmo");
    stall = 1'b0;
    run(0, 1'b0, 4'h3, 8'h00, 3, 8'hA5, 1'b0, "tmo_rd");
`else
    bus.req[0] = 1'b1;
    bus.wr_rd[0] = 1'b0;
    bus.addr[3:0] = 4'h3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", c), {bus.done, ram_en}, 3'b001);
    end
    stall = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done[0] !== 1'b1 && n < 10);
    bus.req[0] = 1'b0;
    chk("stall_done", bus.done, 2'b01);
    chk("stall_err", bus.err, 2'b00);
    chk("stall_rdata", bus.rdata, 8'hA5);
    chk("stall_lat", n, 2);
    @(negedge clk);
`endif
    stall = 1'b1;
    bus.req[1] = 1'b1;
    bus.wr_rd[1] = 1'b0;
    bus.addr[7:4] = 4'h2;
    repeat (3) @(negedge clk);
    chk("mr_rwait", {bus.done, ram_en, ram_wr_rd, ram_addr}, {2'b00, 1'b1, 1'b0, 4'h2});
    #2 rstn = 1'b0;
    #1 chk("mr_async", {bus.done, bus.err, bus.rdata, ram_en, ram_wr_rd, ram_addr, ram_data_in}, 0);
    bus.req[1] = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("mr_hold", {bus.done, ram_en}, 3'b000);
    rstn = 1'b1;
    @(negedge clk);
    chk("mr_post", {bus.done, ram_en}, 3'b000);
    run(1, 1'b0, 4'h2, 8'h00, 3, 8'h22, 1'b0, "mr_rd");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the single-port `ram` block. It accepts independent read/write requests from two masters and grants the shared RAM port round-robin. It drives the RAM's `en`/`wr_rd`/`addr`/`data_in` signals and returns read data, qualified by the RAM's `out_en`, to the owning master. It sits directly between the two masters and the `ram` instance.

## Interface
- `DATA_WIDTH`, default 8: RAM word width; matches `data_width`.
- `ADDR_WIDTH`, default 4: RAM address width; matches `addr_width`.
- `RD_TIMEOUT`, default 8: maximum number of RWAIT cycles before a read is aborted. Must be ≥2.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req`  in  2  request, one bit per master; held high until `done[i]`.
- `wr_rd`  in  2  per master: 1 = write, 0 = read.
- `addr`  in  2*ADDR_WIDTH  per master address; master i uses slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `wdata`  in  2*DATA_WIDTH  per master write data; sliced the same way.
- `done`  out  2  one-cycle completion pulse to the owning master.
- `err`  out  2  one-cycle pulse, coincident with `done`, when a read timed out.
- `rdata`  out  DATA_WIDTH  read data, shared; valid when a read's `done[i]` is high and `err[i]` is low.
- `ram_en`, `ram_wr_rd`  out  1 each  to RAM `en` and `wr_rd`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_data_in`  out  DATA_WIDTH  to RAM `data_in`.
- `ram_data_out`  in  DATA_WIDTH  from RAM `data_out`.
- `ram_out_en`  in  1  from RAM `out_en`; qualifies `ram_data_out`.

## Operation
- The FSM has four states: IDLE, ISSUE, RWAIT, DONE. All outputs are registered.
- **IDLE**
  - If any `req` bit is high, select a winner and latch the winner's `wr_rd`, `addr` and `wdata` into an owner register.
  - Go to ISSUE.
- **Round-robin**
  - Pointer `last` holds the most recently served master.
  - If both masters request, the master ≠ `last` wins.
  - If only one master requests, it wins.
  - `last` updates on entry to DONE.
- **ISSUE**
  - Drive `ram_en`=1, `ram_wr_rd`, `ram_addr` and `ram_data_in` from the latched request.
  - Write: the RAM captures on the closing edge; go to DONE.
  - Read: go to RWAIT.
- **RWAIT**
  - Hold `ram_en`=1, `ram_wr_rd`=0 and `ram_addr`.
  - When `ram_out_en`=1: capture `ram_data_out` into `rdata` and go to DONE.
  - Timeout counter behaviour is defined under Configuration.
- **DONE**
  - Pulse `done[owner]` for one cycle; pulse `err[owner]` if the read timed out.
  - `ram_en`=0. Go to IDLE.
- In all states other than ISSUE and RWAIT, `ram_en`=0. Other `ram_*` outputs hold their last values.
- Request inputs are ignored outside IDLE.
  - A master dropping `req` mid-transaction does not cancel it; `done` still pulses.
  - A master keeping `req` high after `done` is treated as a new request in the next IDLE cycle.
- `rdata` holds its value until the next successful read.
- On a write, `rdata` is unchanged.

## Timing
- **Reset (async, `rstn`=0):** state = IDLE, `last` = 1 (master 0 favoured first). All outputs = 0: `done`, `err`, `rdata`, `ram_en`, `ram_wr_rd`, `ram_addr`, `ram_data_in`.
- **Reset mid-transaction:** the transaction is abandoned with no `done` pulse, and RAM contents are unspecified for an in-flight write.
- **Write latency:** `req` sampled high at edge k. ISSUE is cycle k+1. `done` is high in cycle k+2. Total 2 cycles.
- **Read latency:** 2 + N cycles, where N is the number of RWAIT cycles until `ram_out_en` is seen (N ≥ 1).
- **Issue interval:** minimum 3 cycles between successive RAM accesses.
- **Back-to-back, both requesting continuously:** grants alternate 0,1,0,1, …
- **`ram_out_en` during ISSUE:** ignored; only RWAIT samples it.

## Configuration
- `RAM_ARB_TIMEOUT_EN` defined:
  - An RWAIT counter of `$clog2(RD_TIMEOUT+1)` bits is cleared on entry to RWAIT.
  - If `ram_out_en` has not been seen after `RD_TIMEOUT` RWAIT cycles, go to DONE with `err[owner]`=1.
  - `rdata` is unchanged on a timeout.
- `RAM_ARB_TIMEOUT_EN` undefined:
  - No counter. RWAIT waits indefinitely for `ram_out_en`.
  - `err` is tied to 0.

## Test plan
- **Reset check:** hold `rstn`=0 for 2 cycles with `req`=2'b11. All outputs stay 0 and `ram_en` never rises.
- **Write then read, master 0:** master 0 writes addr 4'h3, data 8'hA5, with `done[0]` 2 cycles after `req`. Master 0 then reads addr 4'h3: `done[0]` with `rdata`=8'hA5 and `err`=0.
- **Contention:** both masters issue writes from the same cycle with `req`=2'b11 held after reset. Grants run 0 then 1 (master 0 writes 4'h1=8'h11, master 1 writes 4'h2=8'h22). Read-back of both addresses returns 8'h11 and 8'h22.
- **Fairness:** hold `req`=2'b11 continuously for 8 transactions. The `done` sequence is 0,1,0,1,0,1,0,1.
- **Mid-transaction reset:** assert `rstn`=0 during RWAIT of a master-1 read. No `done[1]` pulse occurs and outputs return to 0 asynchronously. After release, a new master-1 read completes normally.
- **Timeout:** with `RAM_ARB_TIMEOUT_EN` and `RD_TIMEOUT`=4, force `ram_out_en`=0. `done[0]` and `err[0]` pulse together 4 RWAIT cycles after ISSUE, and `rdata` is unchanged.
